// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - PC/decode/memory-load signal bundle for the instruction-fetch stage.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              stall;
  logic              flush;
  logic              imem_we;
  logic [ADDR_W-3:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic              pc_hold;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_id;
  logic              id_valid;
  logic              misalign_err;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output pc_in, pc_valid, stall, flush, imem_we, imem_waddr, imem_wdata,
    input  pc_hold, instr_out, pc_id, id_valid, misalign_err, fetch_cnt
  );

  modport slave (
    input  pc_in, pc_valid, stall, flush, imem_we, imem_waddr, imem_wdata,
    output pc_hold, instr_out, pc_id, id_valid, misalign_err, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - Instruction fetch with word memory and IF/ID register; FETCH_MISALIGN_TRAP_EN enables the misaligned-PC trap.
module if_fetch_stage #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          CNT_W     = 16
) (
  input logic             clk,
  input logic             reset,
  if_fetch_stage_if.slave fi
);
  localparam int DEPTH = 1 << (ADDR_W - 2);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-3:0] idx;
  logic              misalign;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] pc_id_q;
  logic              valid_q;
  logic              mis_q;
  logic [CNT_W-1:0]  cnt_q;

  assign idx = fi.pc_in[ADDR_W-1:2];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = (fi.pc_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (fi.imem_we) begin
      mem[fi.imem_waddr] <= fi.imem_wdata;
    end
  end

  // Nonblocking read of mem here gives read-before-write against the write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= DATA_W'(NOP_INSTR);
      pc_id_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (fi.flush) begin
      instr_q <= DATA_W'(NOP_INSTR);
      pc_id_q <= fi.pc_in;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (fi.stall) begin
      instr_q <= instr_q;
    end else if (fi.pc_valid) begin
      pc_id_q <= fi.pc_in;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (misalign) begin
        instr_q <= DATA_W'(NOP_INSTR);
        valid_q <= 1'b0;
        mis_q   <= 1'b1;
      end else begin
        instr_q <= mem[idx];
        valid_q <= 1'b1;
        mis_q   <= 1'b0;
      end
    end else begin
      instr_q <= DATA_W'(NOP_INSTR);
      valid_q <= 1'b0;
    end
  end

  assign fi.pc_hold   = fi.stall;
  assign fi.instr_out = instr_q;
  assign fi.pc_id     = pc_id_q;
  assign fi.id_valid  = valid_q;
  assign fi.fetch_cnt = cnt_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fi.misalign_err = mis_q;
`else
  assign fi.misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00500093;
  localparam logic [31:0] I1  = 32'h00A00113;
  localparam logic [31:0] I2  = 32'h00F00193;
  localparam logic [31:0] WA  = 32'hAAAA0001;
  localparam logic [31:0] WB  = 32'hBBBB0002;
  localparam logic [31:0] TOP = 32'hDEADBEEF;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  if_fetch_stage_if #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) fi ();

  if_fetch_stage #(.ADDR_W(10), .DATA_W(32), .NOP_INSTR(32'h00000013), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .fi    (fi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    fi.imem_we    = 1'b1;
    fi.imem_waddr = a;
    fi.imem_wdata = d;
    step();
    fi.imem_we    = 1'b0;
  endtask

  task automatic expect_id(input string tag, input logic [31:0] ins, input logic [9:0] pc,
                           input logic v, input logic [15:0] cnt);
    check({tag, "_instr"}, fi.instr_out, ins);
    check({tag, "_pc"}, 32'(fi.pc_id), 32'(pc));
    check({tag, "_valid"}, 32'(fi.id_valid), 32'(v));
    check({tag, "_cnt"}, 32'(fi.fetch_cnt), 32'(cnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    fi.pc_in = '0;
    fi.pc_valid = 1'b0;
    fi.stall = 1'b0;
    fi.flush = 1'b0;
    fi.imem_we = 1'b0;
    fi.imem_waddr = '0;
    fi.imem_wdata = '0;
    #2;
    expect_id("reset", NOP, 10'h000, 1'b0, 16'd0);
    check("reset_mis", 32'(fi.misalign_err), 32'd0);
    step();
    reset = 1'b0;

    write_word(8'd0, I0);
    write_word(8'd1, I1);
    write_word(8'd2, I2);
    write_word(8'd3, WA);
    write_word(8'd255, TOP);

    fi.pc_valid = 1'b1;
    fi.pc_in = 10'h000;
    step();
    expect_id("fetch0", I0, 10'h000, 1'b1, 16'd1);
    fi.pc_in = 10'h004;
    step();
    expect_id("fetch4", I1, 10'h004, 1'b1, 16'd2);

    fi.pc_in = 10'h008;
    fi.stall = 1'b1;
    #1;
    check("pc_hold", 32'(fi.pc_hold), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_id("stall", I1, 10'h004, 1'b1, 16'd2);
    end
    fi.stall = 1'b0;
    #1;
    check("pc_hold_rel", 32'(fi.pc_hold), 32'd0);
    step();
    expect_id("fetch8", I2, 10'h008, 1'b1, 16'd3);

    fi.pc_in = 10'h00C;
    fi.stall = 1'b1;
    fi.flush = 1'b1;
    step();
    expect_id("flush", NOP, 10'h00C, 1'b0, 16'd3);
    fi.stall = 1'b0;
    fi.flush = 1'b0;

    fi.imem_we = 1'b1;
    fi.imem_waddr = 8'd3;
    fi.imem_wdata = WB;
    step();
    fi.imem_we = 1'b0;
    expect_id("rdw_old", WA, 10'h00C, 1'b1, 16'd4);
    step();
    expect_id("rdw_new", WB, 10'h00C, 1'b1, 16'd5);

    fi.pc_valid = 1'b0;
    step();
    expect_id("bubble", NOP, 10'h00C, 1'b0, 16'd5);

    fi.pc_valid = 1'b1;
    fi.pc_in = 10'h006;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_set_err", 32'(fi.misalign_err), 32'd1);
    check("mis_set_valid", 32'(fi.id_valid), 32'd0);
    check("mis_set_instr", fi.instr_out, NOP);
    check("mis_set_cnt", 32'(fi.fetch_cnt), 32'd6);
`else
    expect_id("mis_off", I1, 10'h006, 1'b1, 16'd6);
    check("mis_off_err", 32'(fi.misalign_err), 32'd0);
`endif
    fi.pc_in = 10'h008;
    step();
    expect_id("mis_clr", I2, 10'h008, 1'b1, 16'd7);
    check("mis_clr_err", 32'(fi.misalign_err), 32'd0);

    fi.pc_in = 10'h3FC;
    step();
    expect_id("top", TOP, 10'h3FC, 1'b1, 16'd8);

    fi.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    expect_id("async_rst", NOP, 10'h000, 1'b0, 16'd0);
    reset = 1'b0;
    fi.stall = 1'b0;
    fi.pc_in = 10'h000;
    step();
    expect_id("post_rst", I0, 10'h000, 1'b1, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
